// File: rtl/dram_arb_pkg.sv
// Shared types for the dRAM arbiter.
// Round-robin tie-break is enabled with DRAM_ARB_RR_EN.
package dram_arb_pkg;

  localparam int DATA_W = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    req_id_t           owner;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } resp_t;

endpackage

// File: rtl/darb_pick.sv
// Combinational winner pick for the dRAM arbiter.
// DRAM_ARB_RR_EN adds the round-robin pointer input.
module darb_pick
  import dram_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef DRAM_ARB_RR_EN
  input  req_id_t    ptr,
`endif
  output logic [1:0] gnt,
  output req_id_t    winner
);

  req_id_t tie;

`ifdef DRAM_ARB_RR_EN
  assign tie = ptr;
`else
  assign tie = REQ0;
`endif

  always_comb begin
    winner = REQ0;
    gnt    = 2'b00;
    if (req == 2'b11) begin
      winner = tie;
    end else if (req[1]) begin
      winner = REQ1;
    end
    if (|req) begin
      gnt = (winner == REQ1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-requester arbiter in front of the single-port dRAM.
// Define DRAM_ARB_RR_EN for round-robin ties; default is fixed priority.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,
  output logic          ram_we,
  output logic [DW-1:0] ram_wd,
  output logic [AW-1:0] ram_a,
  input  logic [DW-1:0] ram_rd
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  req_id_t       winner;
  logic          any;
  logic          sel_we;
  logic [AW-1:0] sel_a;
  logic [DW-1:0] sel_wd;
  logic          mis;

  resp_t resp_d, resp_q;
  logic  vld_d, vld_q;

  // Requests are masked in reset so no grant or write escapes.
  assign req = {r1_req, r0_req} & {2{RST_N}};

`ifdef DRAM_ARB_RR_EN
  req_id_t ptr_d, ptr_q;

  darb_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .winner (winner)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (any) begin
      ptr_d = (winner == REQ0) ? REQ1 : REQ0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= REQ0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  darb_pick u_pick (
    .req    (req),
    .gnt    (gnt),
    .winner (winner)
  );
`endif

  assign any    = |gnt;
  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  always_comb begin
    sel_we = 1'b0;
    sel_a  = '0;
    sel_wd = '0;
    if (any) begin
      sel_we = (winner == REQ1) ? r1_we : r0_we;
      sel_a  = (winner == REQ1) ? r1_addr : r0_addr;
      sel_wd = (winner == REQ1) ? r1_wdata : r0_wdata;
    end
  end

  assign mis    = any && |(sel_a[1:0] & ALIGN_MASK);
  assign ram_we = any && sel_we && !mis;
  assign ram_a  = sel_a;
  assign ram_wd = sel_wd;

  always_comb begin
    resp_d       = '0;
    resp_d.owner = winner;
    resp_d.err   = mis;
    vld_d        = any;
    if (any && !sel_we && !mis) begin
      resp_d.rdata = ram_rd;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      resp_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      resp_q <= resp_d;
      vld_q  <= vld_d;
    end
  end

  assign r0_rvalid = vld_q && (resp_q.owner == REQ0);
  assign r1_rvalid = vld_q && (resp_q.owner == REQ1);
  assign r0_rdata  = r0_rvalid ? resp_q.rdata : '0;
  assign r1_rdata  = r1_rvalid ? resp_q.rdata : '0;
  assign r0_err    = r0_rvalid && resp_q.err;
  assign r1_err    = r1_rvalid && resp_q.err;

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port data RAM (dRAM: CLK, WE, WD, A, RD) between two requesters: requester 0 is the core load/store unit, requester 1 is the debug/DMA port.
- Arbitrates once per cycle and drives the RAM from the winning requester.
- Returns a registered one-cycle response (read data or write ack) to that requester.
- Sits between the requesters and dRAM; it is the only block that drives dRAM's WE, WD and A.

Parameters:
- AW, 32, address width, byte address.
- DW, 32, data width; one RAM word.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- r0_req  in  1  requester 0 access request; held until granted
- r0_we  in  1  requester 0: 1 = write, 0 = read
- r0_addr  in  AW  requester 0 byte address
- r0_wdata  in  DW  requester 0 write data
- r0_gnt  out  1  requester 0 granted this cycle (combinational)
- r0_rvalid  out  1  requester 0 response valid (registered)
- r0_rdata  out  DW  requester 0 read data; 0 for writes and errors
- r0_err  out  1  requester 0 misaligned-access error, qualified by r0_rvalid
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata, r1_err: same as requester 0, for requester 1
- ram_we  out  1  to dRAM WE
- ram_wd  out  DW  to dRAM WD
- ram_a  out  AW  to dRAM A
- ram_rd  in  DW  from dRAM RD; combinational read of ram_a

Behaviour:
- Reset (RST_N low, asynchronous), values forced:
  - all rvalid = 0, all rdata = 0, all err = 0
  - priority pointer = 0
  - response owner register cleared
- Outputs while RST_N is low:
  - gnt outputs = 0
  - ram_we = 0
- Reset mid-operation: any in-flight response is dropped. No RAM write occurs in a cycle where RST_N is low.
- Grant (same cycle as the request):
  - At most one gnt per cycle.
  - Only r0_req set: r0 wins. Only r1_req set: r1 wins.
  - Both set: the winner is chosen by the priority rule (see Optional Feature).
  - No request: ram_we = 0, ram_a and ram_wd = 0.
- RAM drive: ram_a = winner addr, ram_wd = winner wdata, ram_we = winner we AND aligned.
- Aligned means addr[1:0] == 2'b00.
- Misaligned access:
  - Still granted.
  - ram_we is forced to 0, so the RAM is never written.
  - The response carries err = 1 and rdata = 0.
- Response register (state), loaded at the rising edge that ends the grant cycle:
  - owner = winner
  - rdata = ram_rd for an aligned read, else 0
  - err = misaligned
- Response output: the owner's rvalid = 1 for exactly one cycle (cycle N+1 for a grant in cycle N). The other requester's rvalid = 0.
- Fixed latency is 1 cycle for both reads and writes; a write response is an ack.
- Back-to-back: a new grant is allowed every cycle, so a requester holding req high is granted continuously up to the priority rule. Throughput is 1 access per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data. The write commits at the edge ending cycle N, and the read is sampled in cycle N+1.
- The loser of an arbitration must hold req, we, addr and wdata stable until gnt. Behaviour on a dropped request is that it is simply not serviced.
- Address wrap-around is the RAM's concern; the arbiter passes ram_a through unmodified.

Optional Feature:
- Macro: DRAM_ARB_RR_EN
- Defined: round-robin arbitration.
  - 1-bit pointer names the preferred requester.
  - On any grant, pointer <= ~winner, so on a tie the requester that did not win last time wins.
  - Under continuous contention grants alternate r0, r1, r0, ...
- Undefined: fixed priority. r0 always wins ties and the pointer register is not instantiated; r1 can starve.

Decomposition:
- Package dram_arb_pkg:
  - typedef enum logic {REQ0, REQ1} req_id_t
  - typedef struct resp_t {owner, rdata, err}
  - localparam ALIGN_MASK = 2'b11
- Sub-module darb_pick:
  - Combinational winner selection from req[1:0] and the pointer.
  - Outputs gnt[1:0] and winner.
  - Holds the one RR/fixed-priority difference.

Test Plan:
- r0 writes 0xDEADBEEF to 0x10 (r1 idle) -> r0_gnt same cycle; ram_we = 1, ram_a = 0x10. Next cycle r0_rvalid = 1, r0_err = 0. Then r0 reads 0x10 -> next cycle r0_rdata = 0xDEADBEEF.
- Both request reads for 4 cycles, RR_EN defined, r0 -> 0x20 = 0x11, r1 -> 0x24 = 0x22 -> grants r0, r1, r0, r1. Responses alternate 0x11, 0x22 with no gaps.
- Same contention with RR_EN undefined -> r0_gnt = 1 on all 4 cycles; r1_gnt = 0; r1_rvalid never asserted.
- r1 writes 0x5 to misaligned 0x13 -> r1_gnt = 1, ram_we = 0. Next cycle r1_err = 1, r1_rdata = 0. A later read of 0x10 returns its prior contents.
- r0 writes 0xA5A5A5A5 to 0x40 in cycle N, r1 reads 0x40 in cycle N+1 -> r1_rdata = 0xA5A5A5A5 in cycle N+2.
- Assert RST_N low while r0_rvalid = 1 -> r0_rvalid is 0 immediately (asynchronous), ram_we = 0. After release the pointer is 0, so on a tie r0 wins first.
